// File: rtl/cpu_axi_master_if.sv
// AXI4 bus bundle between cpu_axi_master and the slave side of the interconnect.
interface cpu_axi_master_if;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;

  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;

  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;

  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/cpu_axi_master.sv
// Single-outstanding AXI4 master: core request port to INCR read bursts and single-beat writes.
module cpu_axi_master #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_i,
  input  logic                   wr_i,
  input  logic [31:0]            addr_i,
  input  logic [3:0]             len_i,
  input  logic [3:0]             wstrb_i,
  input  logic [31:0]            wdata_i,
  output logic                   busy_o,
  output logic                   rbeat_o,
  output logic [31:0]            rdata_o,
  output logic                   done_o,
  output logic                   err_o,
  cpu_axi_master_if.master       axi
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

  state_t      state, state_nx;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  len_q, wstrb_q, beat_cnt;
  logic        aw_done, w_done, rd_err;
  logic        accept, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic        beat_err, b_err;

  assign accept = (state == S_IDLE) && req_i;
  assign ar_hs  = axi.ARVALID & axi.ARREADY;
  assign r_hs   = axi.RVALID  & axi.RREADY;
  assign aw_hs  = axi.AWVALID & axi.AWREADY;
  assign w_hs   = axi.WVALID  & axi.WREADY;
  assign b_hs   = axi.BVALID  & axi.BREADY;

  // Burst-length mismatch is judged on the RLAST beat: counter holds beats seen before it.
  assign beat_err = (axi.RRESP != 2'b00) | (axi.RID != MASTER_ID) |
                    (axi.RLAST & (beat_cnt != len_q));
  assign b_err    = (axi.BRESP != 2'b00) | (axi.BID != MASTER_ID);

  assign busy_o      = (state != S_IDLE);

  assign axi.ARID    = MASTER_ID;
  assign axi.ARADDR  = addr_q;
  assign axi.ARLEN   = len_q;
  assign axi.ARSIZE  = 3'b010;
  assign axi.ARBURST = 2'b01;
  assign axi.AWID    = MASTER_ID;
  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = '0;
  assign axi.AWSIZE  = 3'b010;
  assign axi.AWBURST = 2'b01;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WLAST   = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    axi.ARVALID = 1'b0;
    axi.RREADY  = 1'b0;
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    axi.BREADY  = 1'b0;
    case (state)
      S_IDLE: if (req_i) state_nx = wr_i ? S_WR : S_AR;
      S_AR: begin
        axi.ARVALID = 1'b1;
        if (axi.ARREADY) state_nx = S_R;
      end
      S_R: begin
        axi.RREADY = 1'b1;
        if (axi.RVALID && axi.RLAST) state_nx = S_IDLE;
      end
      S_WR: begin
        axi.AWVALID = !aw_done;
        axi.WVALID  = !w_done;
        // Either channel may finish first; a same-cycle double handshake goes straight to B.
        if ((aw_done || axi.AWREADY) && (w_done || axi.WREADY)) state_nx = S_B;
      end
      S_B: begin
        axi.BREADY = 1'b1;
        if (axi.BVALID) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      len_q    <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      beat_cnt <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      rd_err   <= 1'b0;
      rdata_o  <= '0;
      rbeat_o  <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      rbeat_o <= r_hs;
      done_o  <= (r_hs & axi.RLAST) | b_hs;
      err_o   <= (r_hs & axi.RLAST & (rd_err | beat_err)) | (b_hs & b_err);
      if (accept) begin
        addr_q  <= {addr_i[31:2], 2'b00};
        len_q   <= len_i;
        wstrb_q <= wstrb_i;
        wdata_q <= wdata_i;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (ar_hs) begin
        beat_cnt <= '0;
        rd_err   <= 1'b0;
      end
      if (r_hs) begin
        rdata_o  <= axi.RDATA;
        beat_cnt <= beat_cnt + 4'd1;
        rd_err   <= rd_err | beat_err;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_axi_master.sv
// Bench for cpu_axi_master: the bench plays the AXI slave and predicts core/bus behaviour per cycle.
module tb_cpu_axi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, wr_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  len_i, wstrb_i;
  logic        busy_o, rbeat_o, done_o, err_o;
  logic [31:0] rdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_axi_master_if axi ();

  cpu_axi_master #(.MASTER_ID(4'd0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_i),
    .wr_i    (wr_i),
    .addr_i  (addr_i),
    .len_i   (len_i),
    .wstrb_i (wstrb_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .rbeat_o (rbeat_o),
    .rdata_o (rdata_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .axi     (axi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    axi.ARREADY = 1'b0; axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
    axi.RVALID  = 1'b0; axi.RLAST   = 1'b0; axi.RDATA  = '0;
    axi.RRESP   = '0;   axi.RID     = '0;
    axi.BVALID  = 1'b0; axi.BRESP   = '0;   axi.BID    = '0;
  endtask

  // Read transaction: nb beats actually returned; error expected for bad resp/id or nb != len+1.
  task automatic run_read(input logic [31:0] a, input logic [3:0] l, input int nb,
                          input int ar_wait, input logic [15:0] gap_mask,
                          input int bad_resp_beat, input int bad_id_beat,
                          input bit keep, input bit noise, input int abort_after, input bit zw);
    logic [31:0] beat_data [16];
    logic [31:0] prev_data;
    bit exp_err, ar_seen, ar_pend, r_pend, last_pend, r_prev, last_prev, done_seen, gapped;
    int c, sent, waited;
    for (int i = 0; i < 16; i++) beat_data[i] = $urandom;
    exp_err = (nb != int'(l) + 1) || (bad_resp_beat >= 0) || (bad_id_beat >= 0);
    prev_data = '0;
    ar_seen = 0; ar_pend = 0; r_pend = 0; last_pend = 0; r_prev = 0; last_prev = 0;
    done_seen = 0; gapped = 0; c = 0; sent = 0; waited = 0;
    req_i = 1'b1; wr_i = 1'b0; addr_i = a; len_i = l;
    wstrb_i = 4'($urandom); wdata_i = $urandom;
    while (!done_seen && c < 300) begin
      step(); c++;
      ar_seen = ar_seen | ar_pend; ar_pend = 0;
      r_prev = r_pend; last_prev = last_pend; r_pend = 0; last_pend = 0;
      check("rd_rbeat", 64'(rbeat_o), 64'(r_prev));
      if (rbeat_o) check("rd_rdata", 64'(rdata_o), 64'(prev_data));
      check("rd_done", 64'(done_o), 64'(last_prev));
      if (done_o) begin
        done_seen = 1;
        check("rd_err", 64'(err_o), 64'(exp_err));
        if (zw) check("rd_latency", 64'(c), 64'(3));
      end
      check("rd_busy", 64'(busy_o), 64'(!last_prev));
      check("rd_arvalid", 64'(axi.ARVALID), 64'(!ar_seen));
      if (axi.ARVALID)
        check("rd_ar_fields",
              64'({axi.ARID, axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST}),
              64'({4'h0, a[31:2], 2'b00, l, 3'b010, 2'b01}));
      check("rd_rready", 64'(axi.RREADY), 64'(ar_seen && !last_prev));
      check("rd_wr_quiet", 64'({axi.AWVALID, axi.WVALID, axi.BREADY}), 64'(0));
      if (abort_after > 0 && sent == abort_after) begin
        rst_n = 1'b0;
        #1;
        check("rst_outputs", 64'({axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID,
                                  axi.BREADY, busy_o, rbeat_o, done_o, err_o}), 64'(0));
        check("rst_rdata", 64'(rdata_o), 64'(0));
        idle_bus(); req_i = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        check("rst_no_done", 64'({done_o, busy_o}), 64'(0));
        return;
      end
      if (done_seen) begin
        idle_bus();
        req_i = keep;
      end else begin
        if (c == 1 && !keep) req_i = 1'b0;
        if (noise && !keep) begin
          req_i = 1'($urandom); wr_i = 1'($urandom);
          addr_i = $urandom; len_i = 4'($urandom);
        end
        axi.ARREADY = 1'b0;
        if (axi.ARVALID) begin
          axi.ARREADY = (waited >= ar_wait);
          waited++;
          ar_pend = axi.ARREADY;
        end
        axi.RVALID = 1'b0;
        if (ar_seen && sent < nb) begin
          if (gap_mask[4'(sent)] && !gapped) gapped = 1;
          else begin
            axi.RVALID = 1'b1;
            axi.RDATA  = beat_data[4'(sent)];
            axi.RLAST  = (sent == nb - 1);
            axi.RRESP  = (sent == bad_resp_beat) ? 2'b10 : 2'b00;
            axi.RID    = (sent == bad_id_beat) ? 4'h5 : 4'h0;
            if (axi.RREADY) begin
              r_pend = 1; last_pend = axi.RLAST;
              prev_data = beat_data[4'(sent)];
              sent++; gapped = 0;
            end
          end
        end
      end
    end
    check("rd_finished", 64'(done_seen), 64'(1));
  endtask

  task automatic run_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_wait, input int w_wait, input int b_wait,
                           input logic [1:0] bresp, input logic [3:0] bid,
                           input bit keep, input bit noise, input bit zw);
    bit exp_err, aw_seen, w_seen, aw_pend, w_pend, b_pend, b_prev, done_seen;
    int c, bcnt;
    exp_err = (bresp != 2'b00) || (bid != 4'h0);
    aw_seen = 0; w_seen = 0; aw_pend = 0; w_pend = 0; b_pend = 0; b_prev = 0;
    done_seen = 0; c = 0; bcnt = 0;
    req_i = 1'b1; wr_i = 1'b1; addr_i = a; wdata_i = d; wstrb_i = s; len_i = 4'($urandom);
    while (!done_seen && c < 300) begin
      step(); c++;
      aw_seen = aw_seen | aw_pend; w_seen = w_seen | w_pend; b_prev = b_pend;
      aw_pend = 0; w_pend = 0; b_pend = 0;
      check("wr_done", 64'(done_o), 64'(b_prev));
      if (done_o) begin
        done_seen = 1;
        check("wr_err", 64'(err_o), 64'(exp_err));
        if (zw) check("wr_latency", 64'(c), 64'(3));
      end
      check("wr_busy", 64'(busy_o), 64'(!b_prev));
      check("wr_awvalid", 64'(axi.AWVALID), 64'(!aw_seen));
      check("wr_wvalid", 64'(axi.WVALID), 64'(!w_seen));
      if (axi.AWVALID)
        check("wr_aw_fields",
              64'({axi.AWID, axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST}),
              64'({4'h0, a[31:2], 2'b00, 4'h0, 3'b010, 2'b01}));
      if (axi.WVALID)
        check("wr_w_fields", 64'({axi.WDATA, axi.WSTRB, axi.WLAST}), 64'({d, s, 1'b1}));
      check("wr_bready", 64'(axi.BREADY), 64'(aw_seen && w_seen && !b_prev));
      check("wr_rd_quiet", 64'({axi.ARVALID, axi.RREADY}), 64'(0));
      if (done_seen) begin
        idle_bus();
        req_i = keep;
      end else begin
        if (c == 1 && !keep) req_i = 1'b0;
        if (noise && !keep) begin
          req_i = 1'($urandom); wr_i = 1'($urandom);
          addr_i = $urandom; wdata_i = $urandom; wstrb_i = 4'($urandom);
        end
        axi.AWREADY = axi.AWVALID && (c - 1 >= aw_wait);
        aw_pend = axi.AWREADY;
        axi.WREADY = axi.WVALID && (c - 1 >= w_wait);
        w_pend = axi.WREADY;
        axi.BVALID = 1'b0;
        if (aw_seen && w_seen) begin
          if (bcnt >= b_wait) begin
            axi.BVALID = 1'b1; axi.BRESP = bresp; axi.BID = bid;
            b_pend = axi.BREADY;
          end
          bcnt++;
        end
      end
    end
    check("wr_finished", 64'(done_seen), 64'(1));
  endtask

  logic [3:0] rl;
  int         rnb, rbr, rbi;
  bit         rkeep, rnoise;

  initial begin
    rst_n = 1'b0; req_i = 1'b0; wr_i = 1'b0; addr_i = '0; len_i = '0;
    wstrb_i = '0; wdata_i = '0;
    idle_bus();
    step(); step();
    check("reset_outputs", 64'({axi.ARVALID, axi.RREADY, axi.AWVALID, axi.WVALID,
                                axi.BREADY, busy_o, rbeat_o, done_o, err_o}), 64'(0));
    check("reset_rdata", 64'(rdata_o), 64'(0));
    rst_n = 1'b1;
    step();

    run_read(32'h0000_1006, 4'd0, 1, 0, 16'h0000, -1, -1, 0, 0, 0, 1);
    run_read(32'h0000_2000, 4'd3, 4, 2, 16'h0004, -1, -1, 0, 0, 0, 0);
    run_write(32'h0000_3008, 32'hDEAD_BEEF, 4'b0011, 0, 2, 0, 2'b00, 4'h0, 0, 0, 0);
    run_write(32'h0000_300C, 32'h0000_0001, 4'hF, 0, 0, 0, 2'b00, 4'h0, 0, 0, 1);
    run_write(32'h0000_3010, 32'h0000_0002, 4'hF, 0, 0, 0, 2'b10, 4'h0, 0, 0, 1);
    run_read(32'h0000_4000, 4'd3, 2, 0, 16'h0000, -1, -1, 0, 0, 0, 0);
    run_read(32'h0000_5000, 4'd1, 2, 1, 16'h0000, -1, -1, 1, 0, 0, 0);
    run_write(32'h0000_5004, 32'hCAFE_F00D, 4'hC, 1, 0, 1, 2'b00, 4'h0, 0, 1, 0);
    run_read(32'h0000_6000, 4'd7, 8, 0, 16'hFFFF, 3, -1, 0, 1, 0, 0);
    step();
    check("idle_after_noise", 64'(busy_o), 64'(0));
    run_read(32'h0000_7000, 4'd3, 4, 0, 16'h0000, -1, -1, 0, 0, 1, 0);
    run_read(32'h0000_7100, 4'd3, 4, 0, 16'h0000, -1, -1, 0, 0, 0, 0);
    run_read(32'h0000_7200, 4'd15, 16, 1, 16'h0000, -1, -1, 0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      rkeep  = (t != 39) && ($urandom_range(0, 3) == 0);
      rnoise = !rkeep && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) begin
        rl  = 4'($urandom);
        rnb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 16)) : int'(rl) + 1;
        rbr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 32'(rnb - 1))) : -1;
        rbi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 32'(rnb - 1))) : -1;
        run_read($urandom, rl, rnb, int'($urandom_range(0, 3)), 16'($urandom),
                 rbr, rbi, rkeep, rnoise, 0, 0);
      end else begin
        run_write($urandom, $urandom, 4'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  ($urandom_range(0, 7) == 0) ? 4'h9 : 4'h0,
                  rkeep, rnoise, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
